gps_correlator_bank: RTL and testbench
======================================

Name: gps_correlator_bank

Overview:
- Parametrised multi-tap integrate-and-dump correlator for one GPS tracking channel. Generalises the fixed early/punctual/late I/Q correlator to N_TAPS replica taps (e.g. VE/E/P/L/VL) with configurable widths.
- Each tap wipes the code off the carrier-stripped baseband I/Q samples and accumulates over a run-time number of code epochs.
- Each tap dumps a result set through a valid/ready handshake to the loop-filter/discriminator stage.

Parameters:
- W_IN, 16, signed width of sample_i/sample_q.
- ACC_W, 32, signed accumulator and output width per tap (ACC_W > W_IN).
- N_TAPS, 3, number of replica code taps; tap 0 = earliest.
- CNT_W, 8, width of integ_len and the internal epoch counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  channel enable; low clears accumulators and returns to IDLE.
- sample_valid  in  1  qualifies sample_i/sample_q/code_chips/epoch.
- sample_i  in  W_IN  signed in-phase baseband sample.
- sample_q  in  W_IN  signed quadrature baseband sample.
- code_chips  in  N_TAPS  replica chip per tap; 1 = +1, 0 = -1.
- epoch  in  1  marks the first sample of a new code period (valid only with sample_valid).
- integ_len  in  CNT_W  epochs per integration; 0 treated as 1; sampled at each dump.
- out_valid  out  1  dump result available.
- out_ready  in  1  consumer accepts the result.
- out_i  out  N_TAPS*ACC_W  packed signed I sums; tap k at [k*ACC_W +: ACC_W].
- out_q  out  N_TAPS*ACC_W  packed signed Q sums, same packing.
- out_sat  out  1  at least one accumulator clamped during the dumped period.
- out_overrun  out  1  sticky: a dump overwrote an unaccepted result.

Behaviour:
- Reset is synchronous, active-high, on clk only. All outputs, accumulators and the epoch counter go to 0 and the state to IDLE. out_overrun is cleared only by rst.
- States:
  - IDLE -> ACCUM on a cycle with enable & sample_valid & epoch. That sample is accumulated as the first of the period; no dump occurs.
  - ACCUM -> IDLE when enable = 0. Accumulators, the epoch counter and the sat flag are cleared; pending output is untouched.
- Per accepted sample in ACCUM, for each tap k: acc_i[k] += chip[k] ? sample_i : -sample_i. Same rule for acc_q[k] with sample_q.
  - Negation of the most-negative W_IN value is computed in W_IN+1 bits. No wrap.
- Saturation: each sum clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Any clamp sets the internal sat flag for the current period.
- Epoch counter: increments on each epoch sample in ACCUM.
- Dump condition: sample_valid & epoch & ACCUM & (epoch_cnt == max(integ_len,1)-1). On the dump cycle:
  - out_i/out_q load the accumulators excluding the current sample.
  - out_sat loads the sat flag.
  - Accumulators load the current sample's product (a fresh period starts; the sat flag restarts from that product).
  - epoch_cnt goes to 0.
- Latency: out_valid rises on the clock edge that ends the dump cycle, i.e. it is visible one cycle after the epoch sample.
- Handshake:
  - out_valid holds until out_valid & out_ready; it is then cleared on the next edge unless a new dump occurs on the same cycle, in which case it stays 1 with the new data.
  - Data is stable while out_valid & !out_ready, except on an overrun.
- Overrun: a dump while out_valid & !out_ready overwrites out_i/out_q/out_sat and sets out_overrun. No stall; sample input is never back-pressured.
- sample_valid = 0: no state change except the handshake.
- epoch without sample_valid is ignored.
- Changing integ_len mid-period takes effect at the next comparison.

Test Plan:
- Reset check: assert rst 2 cycles with random inputs -> out_valid=0, out_i=out_q=0, out_sat=0, out_overrun=0. Release; the first epoch causes no dump.
- Basic dump: N_TAPS=3, integ_len=1, out_ready=1, chips=3'b110, constant I=10, Q=-5, epoch every 4 samples.
  - -> One cycle after the 2nd epoch: out_valid=1, taps 2,1 = (40,-20), tap 0 = (-40,20).
  - Repeats every 4 samples with identical values.
- Multi-epoch: same stimulus with integ_len=3 -> dumps every 12 samples, taps 2,1 = (120,-60). integ_len=0 behaves as 1.
- Saturation: instance ACC_W=10, W_IN=8, I=127, chips all 1, integ_len=1, 5-sample periods -> out_i taps = 511, out_sat=1. With I=-128 -> -512, out_sat=1. The next period at I=1 gives 5, out_sat=0.
- Backpressure: out_ready=0 across two dumps -> out_overrun=1, data equals the 2nd dump. Raise out_ready -> out_valid drops the next cycle; out_overrun stays 1 until rst.
- Mid-operation reset/disable:
  - rst pulsed halfway through a period -> no dump until an epoch rearms, then the next dump sums only post-rearm samples.
  - enable=0 for 1 cycle mid-period -> same rearm behaviour; pending out_valid is preserved.

Source files
------------

// File: rtl/gps_correlator_bank.sv
// gps_correlator_bank
//   Multi-tap integrate-and-dump correlator for one GPS tracking channel.
//   Each of N_TAPS replica taps wipes its code chip off the carrier-stripped
//   I/Q samples and accumulates the result, with saturation, over integ_len
//   code epochs. Each period's result set is presented through a
//   valid/ready handshake to the discriminator stage.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   enable          channel enable; low clears accumulators and returns to IDLE
//   sample_valid    qualifies sample_i / sample_q / code_chips / epoch
//   sample_i/_q     signed baseband samples, W_IN bits
//   code_chips      replica chip per tap (1 = +1, 0 = -1), tap 0 earliest
//   epoch           first sample of a new code period
//   integ_len       epochs per integration (0 behaves as 1)
//   out_valid       dump result available; out_ready accepts it
//   out_i/out_q     packed signed sums, tap k at [k*ACC_W +: ACC_W]
//   out_sat         an accumulator clamped during the dumped period
//   out_overrun     sticky: a dump overwrote an unaccepted result
module gps_correlator_bank #(
  parameter int W_IN   = 16,
  parameter int ACC_W  = 32,
  parameter int N_TAPS = 3,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     sample_valid,
  input  logic [W_IN-1:0]          sample_i,
  input  logic [W_IN-1:0]          sample_q,
  input  logic [N_TAPS-1:0]        code_chips,
  input  logic                     epoch,
  input  logic [CNT_W-1:0]         integ_len,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_TAPS*ACC_W-1:0]  out_i,
  output logic [N_TAPS*ACC_W-1:0]  out_q,
  output logic                     out_sat,
  output logic                     out_overrun
);

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  // Code wipe-off. The sample is widened by one bit first so negating the
  // most-negative value cannot wrap.
  function automatic logic signed [W_IN:0] wipe(input logic [W_IN-1:0] s,
                                                input logic chip);
    logic signed [W_IN:0] ext;
    ext = $signed({s[W_IN-1], s});
    return chip ? ext : -ext;
  endfunction

  // Clamp a one-bit-wider sum back into the accumulator range.
  function automatic logic signed [ACC_W-1:0] clamp(input logic signed [ACC_W:0] s);
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  state_t                   r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_sat;
  logic signed [ACC_W-1:0]  r_acc_i [N_TAPS];
  logic signed [ACC_W-1:0]  r_acc_q [N_TAPS];
  logic                     r_out_valid;
  logic [N_TAPS*ACC_W-1:0]  r_out_i;
  logic [N_TAPS*ACC_W-1:0]  r_out_q;
  logic                     r_out_sat;
  logic                     r_overrun;

  logic signed [W_IN:0]     w_prod_i [N_TAPS];
  logic signed [W_IN:0]     w_prod_q [N_TAPS];
  logic signed [ACC_W:0]    w_pext_i [N_TAPS];
  logic signed [ACC_W:0]    w_pext_q [N_TAPS];
  logic signed [ACC_W:0]    w_sum_i  [N_TAPS];
  logic signed [ACC_W:0]    w_sum_q  [N_TAPS];
  logic [N_TAPS-1:0]        w_ovf_i;
  logic [N_TAPS-1:0]        w_ovf_q;
  logic [CNT_W-1:0]         w_last_cnt;
  logic                     w_dump;

  // Products and one-bit-wider sums; a sum overflows ACC_W when its top two
  // bits differ.
  always_comb begin
    for (int k = 0; k < N_TAPS; k++) begin
      w_prod_i[k] = wipe(sample_i, code_chips[k]);
      w_prod_q[k] = wipe(sample_q, code_chips[k]);
      w_pext_i[k] = $signed({{(ACC_W-W_IN){w_prod_i[k][W_IN]}}, w_prod_i[k]});
      w_pext_q[k] = $signed({{(ACC_W-W_IN){w_prod_q[k][W_IN]}}, w_prod_q[k]});
      w_sum_i[k]  = $signed({r_acc_i[k][ACC_W-1], r_acc_i[k]}) + w_pext_i[k];
      w_sum_q[k]  = $signed({r_acc_q[k][ACC_W-1], r_acc_q[k]}) + w_pext_q[k];
      w_ovf_i[k]  = w_sum_i[k][ACC_W] ^ w_sum_i[k][ACC_W-1];
      w_ovf_q[k]  = w_sum_q[k][ACC_W] ^ w_sum_q[k][ACC_W-1];
    end
  end

  assign w_last_cnt = (integ_len == '0) ? '0 : integ_len - CNT_W'(1);
  assign w_dump     = enable & sample_valid & epoch & (r_state == S_ACCUM) &
                      (r_cnt == w_last_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_i     <= '0;
      r_out_q     <= '0;
      r_out_sat   <= 1'b0;
      r_overrun   <= 1'b0;
      for (int k = 0; k < N_TAPS; k++) begin
        r_acc_i[k] <= '0;
        r_acc_q[k] <= '0;
      end
    end else begin
      // Accepted result retires; a dump below on this same cycle overrides.
      if (r_out_valid && out_ready)
        r_out_valid <= 1'b0;

      if (!enable) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_sat   <= 1'b0;
        for (int k = 0; k < N_TAPS; k++) begin
          r_acc_i[k] <= '0;
          r_acc_q[k] <= '0;
        end
      end else if (sample_valid) begin
        case (r_state)
          S_IDLE: begin
            if (epoch) begin
              // Arming epoch is the first sample of the period; a single
              // product always fits ACC_W, so no clamp and no sat here.
              r_state <= S_ACCUM;
              r_cnt   <= '0;
              r_sat   <= 1'b0;
              for (int k = 0; k < N_TAPS; k++) begin
                r_acc_i[k] <= w_pext_i[k][ACC_W-1:0];
                r_acc_q[k] <= w_pext_q[k][ACC_W-1:0];
              end
            end
          end
          S_ACCUM: begin
            if (w_dump) begin
              for (int k = 0; k < N_TAPS; k++) begin
                r_out_i[k*ACC_W +: ACC_W] <= r_acc_i[k];
                r_out_q[k*ACC_W +: ACC_W] <= r_acc_q[k];
                r_acc_i[k] <= w_pext_i[k][ACC_W-1:0];
                r_acc_q[k] <= w_pext_q[k][ACC_W-1:0];
              end
              r_out_sat   <= r_sat;
              r_out_valid <= 1'b1;
              if (r_out_valid && !out_ready)
                r_overrun <= 1'b1;
              r_sat <= 1'b0;
              r_cnt <= '0;
            end else begin
              for (int k = 0; k < N_TAPS; k++) begin
                r_acc_i[k] <= clamp(w_sum_i[k]);
                r_acc_q[k] <= clamp(w_sum_q[k]);
              end
              r_sat <= r_sat | (|w_ovf_i) | (|w_ovf_q);
              if (epoch)
                r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_i       = r_out_i;
  assign out_q       = r_out_q;
  assign out_sat     = r_out_sat;
  assign out_overrun = r_overrun;

endmodule

// File: tb/tb_gps_correlator_bank.sv
module tb_gps_correlator_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic        epoch = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  s_i = '0;
  logic [7:0]  s_q = '0;
  logic [2:0]  chips = '0;
  logic [7:0]  integ_len = 8'd1;

  // Instance A: default widths (W_IN=16, ACC_W=32), fed sign-extended samples.
  logic        a_valid, a_sat, a_ovr;
  logic [95:0] a_out_i, a_out_q;
  // Instance B: W_IN=8, ACC_W=10, so saturation is reachable.
  logic        b_valid, b_sat, b_ovr;
  logic [29:0] b_out_i, b_out_q;

  gps_correlator_bank dut_a (
    .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
    .sample_i({{8{s_i[7]}}, s_i}), .sample_q({{8{s_q[7]}}, s_q}),
    .code_chips(chips), .epoch(epoch), .integ_len(integ_len),
    .out_valid(a_valid), .out_ready(out_ready), .out_i(a_out_i), .out_q(a_out_q),
    .out_sat(a_sat), .out_overrun(a_ovr));

  gps_correlator_bank #(.W_IN(8), .ACC_W(10), .N_TAPS(3), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
    .sample_i(s_i), .sample_q(s_q),
    .code_chips(chips), .epoch(epoch), .integ_len(integ_len),
    .out_valid(b_valid), .out_ready(out_ready), .out_i(b_out_i), .out_q(b_out_q),
    .out_sat(b_sat), .out_overrun(b_ovr));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model: the samples of the current period are kept in queues and
  // the period sums are evaluated only when the period is dumped.
  int         q_i[$];
  int         q_q[$];
  logic [2:0] q_c[$];
  bit         m_armed = 1'b0;
  int         m_nep = 0;
  logic       e_valid = 1'b0;
  logic       e_ovr = 1'b0;
  logic       e_sat [2] = '{1'b0, 1'b0};
  longint     e_i [2][3];
  longint     e_q [2][3];

  function automatic int acc_w(int d);
    return (d == 0) ? 32 : 10;
  endfunction

  function automatic longint dut_i(int d, int k);
    if (d == 0) return longint'($signed(a_out_i[k*32 +: 32]));
    return longint'($signed(b_out_i[k*10 +: 10]));
  endfunction
  function automatic longint dut_q(int d, int k);
    if (d == 0) return longint'($signed(a_out_q[k*32 +: 32]));
    return longint'($signed(b_out_q[k*10 +: 10]));
  endfunction
  function automatic logic dut_v(int d);   return (d == 0) ? a_valid : b_valid; endfunction
  function automatic logic dut_s(int d);   return (d == 0) ? a_sat   : b_sat;   endfunction
  function automatic logic dut_o(int d);   return (d == 0) ? a_ovr   : b_ovr;   endfunction

  task automatic cmp(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic start_period(input int si, input int sq);
    q_i.delete(); q_q.delete(); q_c.delete();
    q_i.push_back(si); q_q.push_back(sq); q_c.push_back(chips);
    m_nep = 1;
  endtask

  task automatic model_dump();
    for (int d = 0; d < 2; d++) begin
      longint mx = (longint'(1) << (acc_w(d) - 1)) - 1;
      longint mn = -(longint'(1) << (acc_w(d) - 1));
      bit sat = 1'b0;
      for (int k = 0; k < 3; k++) begin
        longint ai = 0;
        longint aq = 0;
        for (int s = 0; s < q_i.size(); s++) begin
          ai += q_c[s][k] ? q_i[s] : -q_i[s];
          aq += q_c[s][k] ? q_q[s] : -q_q[s];
          if (ai > mx) begin ai = mx; sat = 1'b1; end
          if (ai < mn) begin ai = mn; sat = 1'b1; end
          if (aq > mx) begin aq = mx; sat = 1'b1; end
          if (aq < mn) begin aq = mn; sat = 1'b1; end
        end
        e_i[d][k] = ai;
        e_q[d][k] = aq;
      end
      e_sat[d] = sat;
    end
  endtask

  task automatic model_step();
    bit ack, dumped;
    int len, si, sq;
    if (rst) begin
      e_valid = 1'b0; e_ovr = 1'b0; m_armed = 1'b0; m_nep = 0;
      q_i.delete(); q_q.delete(); q_c.delete();
      for (int d = 0; d < 2; d++) begin
        e_sat[d] = 1'b0;
        for (int k = 0; k < 3; k++) begin e_i[d][k] = 0; e_q[d][k] = 0; end
      end
      return;
    end
    ack    = e_valid && out_ready;
    dumped = 1'b0;
    si     = int'($signed(s_i));
    sq     = int'($signed(s_q));
    len    = (integ_len == 0) ? 1 : int'(integ_len);
    if (!enable) begin
      m_armed = 1'b0; m_nep = 0;
      q_i.delete(); q_q.delete(); q_c.delete();
    end else if (sample_valid) begin
      if (!m_armed) begin
        if (epoch) begin
          m_armed = 1'b1;
          start_period(si, sq);
        end
      end else if (epoch && m_nep == len) begin
        model_dump();
        if (e_valid && !out_ready) e_ovr = 1'b1;
        e_valid = 1'b1;
        dumped  = 1'b1;
        start_period(si, sq);
      end else begin
        q_i.push_back(si); q_q.push_back(sq); q_c.push_back(chips);
        if (epoch) m_nep++;
      end
    end
    if (ack && !dumped) e_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic feed(input int i, input int q, input logic [2:0] c, input bit ep);
    sample_valid = 1'b1; s_i = 8'(i); s_q = 8'(q); chips = c; epoch = ep;
    tick();
  endtask

  task automatic idle();
    sample_valid = 1'b0; epoch = 1'b0;
    tick();
  endtask

  task automatic dis();
    enable = 1'b0; sample_valid = 1'b0; epoch = 1'b0;
    tick();
    enable = 1'b1;
  endtask

  // Hand-computed expectations: taps 2 and 1 carry (i2,q2), tap 0 (i0,q0).
  task automatic lit_dump(input string nm, input int d, input longint i2, input longint q2,
                          input longint i0, input longint q0,
                          input bit v, input bit sat, input bit ovr);
    string p = $sformatf("%s %s", nm, (d == 0) ? "A" : "B");
    cmp({p, " out_valid"},   dut_v(d), v);
    cmp({p, " out_sat"},     dut_s(d), sat);
    cmp({p, " out_overrun"}, dut_o(d), ovr);
    cmp({p, " out_i[2]"}, dut_i(d, 2), i2);
    cmp({p, " out_i[1]"}, dut_i(d, 1), i2);
    cmp({p, " out_i[0]"}, dut_i(d, 0), i0);
    cmp({p, " out_q[2]"}, dut_q(d, 2), q2);
    cmp({p, " out_q[1]"}, dut_q(d, 1), q2);
    cmp({p, " out_q[0]"}, dut_q(d, 0), q0);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        string p = (d == 0) ? "A" : "B";
        cmp({p, " model out_valid"},   dut_v(d), e_valid);
        cmp({p, " model out_overrun"}, dut_o(d), e_ovr);
        cmp({p, " model out_sat"},     dut_s(d), e_sat[d]);
        for (int k = 0; k < 3; k++) begin
          cmp($sformatf("%s model out_i[%0d]", p, k), dut_i(d, k), e_i[d][k]);
          cmp($sformatf("%s model out_q[%0d]", p, k), dut_q(d, k), e_q[d][k]);
        end
      end
    end
  end

  initial begin
    // Reset with random inputs.
    for (int c = 0; c < 2; c++) begin
      enable = 1'($urandom); sample_valid = 1'($urandom); epoch = 1'($urandom);
      out_ready = 1'($urandom); s_i = 8'($urandom); s_q = 8'($urandom);
      chips = 3'($urandom); integ_len = 8'($urandom);
      tick();
      chk_en = 1'b1;
    end
    for (int d = 0; d < 2; d++) lit_dump("reset", d, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0; enable = 1'b1; out_ready = 1'b1; integ_len = 8'd1;
    sample_valid = 1'b0; epoch = 1'b0;

    // Basic dump, integ_len=1, epoch every 4 samples.
    for (int n = 0; n <= 12; n++) begin
      feed(10, -5, 3'b110, (n % 4) == 0);
      if (n == 0 || n == 5)
        for (int d = 0; d < 2; d++) cmp($sformatf("basic n%0d valid", n), dut_v(d), 1'b0);
      if (n == 4 || n == 8 || n == 12)
        for (int d = 0; d < 2; d++) lit_dump("basic", d, 40, -20, -40, 20, 1, 0, 0);
    end
    cmp("model pin basic tap2", e_i[0][2], 40);

    // Multi-epoch integration.
    dis();
    integ_len = 8'd3;
    for (int n = 0; n <= 24; n++) begin
      feed(10, -5, 3'b110, (n % 4) == 0);
      if (n == 8)
        for (int d = 0; d < 2; d++) cmp("multi n8 valid", dut_v(d), 1'b0);
      if (n == 12 || n == 24)
        for (int d = 0; d < 2; d++) lit_dump("multi", d, 120, -60, -120, 60, 1, 0, 0);
    end

    // integ_len = 0 behaves as 1.
    dis();
    integ_len = 8'd0;
    for (int n = 0; n <= 8; n++) begin
      feed(10, -5, 3'b110, (n % 4) == 0);
      if (n == 4 || n == 8)
        for (int d = 0; d < 2; d++) lit_dump("len0", d, 40, -20, -40, 20, 1, 0, 0);
    end

    // Saturation: 5-sample periods, chips all +1.
    dis();
    integ_len = 8'd1;
    for (int n = 0; n <= 15; n++) begin
      feed((n < 5) ? 127 : (n < 10) ? -128 : 1, 0, 3'b111, (n % 5) == 0);
      if (n == 5) begin
        lit_dump("sat+", 0, 635, 0, 635, 0, 1, 0, 0);
        lit_dump("sat+", 1, 511, 0, 511, 0, 1, 1, 0);
      end
      if (n == 10) begin
        lit_dump("sat-", 0, -640, 0, -640, 0, 1, 0, 0);
        lit_dump("sat-", 1, -512, 0, -512, 0, 1, 1, 0);
      end
      if (n == 15)
        for (int d = 0; d < 2; d++) lit_dump("sat clear", d, 5, 0, 5, 0, 1, 0, 0);
    end

    // Backpressure across two dumps.
    dis();
    out_ready = 1'b0;
    for (int n = 0; n <= 8; n++) begin
      feed((n < 4) ? 1 : (n < 8) ? 2 : 3, (n < 4) ? -1 : (n < 8) ? -3 : 0,
           3'b110, (n % 4) == 0);
      if (n == 4)
        for (int d = 0; d < 2; d++) lit_dump("bp first", d, 4, -4, -4, 4, 1, 0, 0);
      if (n == 8)
        for (int d = 0; d < 2; d++) lit_dump("bp overrun", d, 8, -12, -8, 12, 1, 0, 1);
    end
    out_ready = 1'b1;
    idle();
    for (int d = 0; d < 2; d++) begin
      cmp("bp accept valid", dut_v(d), 1'b0);
      cmp("bp accept overrun", dut_o(d), 1'b1);
    end
    idle();
    for (int d = 0; d < 2; d++) cmp("bp sticky overrun", dut_o(d), 1'b1);

    // Reset mid-period, then rearm.
    feed(5, 1, 3'b110, 0);
    feed(5, 1, 3'b110, 0);
    rst = 1'b1;
    feed(99, 1, 3'b110, 1);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) lit_dump("mid rst", d, 0, 0, 0, 0, 0, 0, 0);
    out_ready = 1'b0;
    feed(7, 1, 3'b110, 0);
    feed(7, 1, 3'b110, 0);
    feed(3, 1, 3'b110, 1);
    for (int n = 0; n < 3; n++) feed(3, 1, 3'b110, 0);
    feed(3, 1, 3'b110, 1);
    for (int d = 0; d < 2; d++) lit_dump("rearm", d, 12, 4, -12, -4, 1, 0, 0);

    // One-cycle disable mid-period with a result pending.
    feed(3, 1, 3'b110, 0);
    enable = 1'b0;
    feed(50, 1, 3'b110, 1);
    enable = 1'b1;
    for (int d = 0; d < 2; d++) lit_dump("disable hold", d, 12, 4, -12, -4, 1, 0, 0);
    feed(9, 1, 3'b110, 0);
    feed(9, 1, 3'b110, 0);
    feed(2, 1, 3'b110, 1);
    for (int n = 0; n < 3; n++) feed(2, 1, 3'b110, 0);
    feed(2, 1, 3'b110, 1);
    for (int d = 0; d < 2; d++) lit_dump("disable rearm", d, 8, 4, -8, -4, 1, 0, 1);
    out_ready = 1'b1;
    idle();
    for (int d = 0; d < 2; d++) cmp("final accept valid", dut_v(d), 1'b0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
